// File: rtl/fetch_queue_pkg.sv
// Shared widths and the instruction-id advance rule for the fetch queue.
// The global width macros live here so every importer sees one definition.
`ifndef FETCH_QUEUE_DEFINES_VH
`define FETCH_QUEUE_DEFINES_VH
`define INST_WIDTH           32
`define ADDR_WIDTH           32
`define INSTRUCTION_ID_WIDTH 4
`define FETCH_QUEUE_DEPTH    4
`endif

package fetch_queue_pkg;

  localparam int INST_W        = `INST_WIDTH;
  localparam int ADDR_W        = `ADDR_WIDTH;
  localparam int ID_W          = `INSTRUCTION_ID_WIDTH;
  localparam int FQ_DEPTH      = `FETCH_QUEUE_DEPTH;
  localparam int FQ_DEPTH_LOG2 = $clog2(`FETCH_QUEUE_DEPTH);

  // Ids 0 and 1 are reserved (0 marks a bubble downstream), so wrap lands on 2.
  function automatic logic [ID_W-1:0] id_advance(input logic [ID_W-1:0] id);
    logic [ID_W-1:0] nxt;
    nxt = id + ID_W'(2);
    return (nxt == '0) ? ID_W'(2) : nxt;
  endfunction

endpackage

// File: rtl/id_allocator.sv
// In-order instruction-id pair generator; ids are valid combinationally, advance at posedge on alloc.
// No backpressure: the caller only raises alloc for pairs that are actually enqueued.
module id_allocator
  import fetch_queue_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            alloc,
  output logic [ID_W-1:0] id0,
  output logic [ID_W-1:0] id1
);

  logic [ID_W-1:0] next_id;

  always_ff @(posedge clk) begin
    if (reset)
      next_id <= ID_W'(2);
    else if (alloc)
      next_id <= id_advance(next_id);
  end

  // next_id is always even, so +1 never wraps into the reserved range.
  assign id0 = next_id;
  assign id1 = next_id + ID_W'(1);

endmodule

// File: rtl/fetch_queue.sv
// Instruction-pair FWFT buffer with in-order id assignment; push-to-output latency 1 cycle, no bypass.
// Fetch holds on full (a push while full is dropped); issue holds the head with stall; flush empties.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH      = FQ_DEPTH,
  parameter int DEPTH_LOG2 = FQ_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  push,
  input  logic [INST_W-1:0]     instruction0_in,
  input  logic [INST_W-1:0]     instruction1_in,
  input  logic [ADDR_W-1:0]     pc0_in,
  input  logic [ADDR_W-1:0]     pc1_in,
  input  logic                  stall,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count,
  output logic [INST_W-1:0]     instruction0_out,
  output logic [INST_W-1:0]     instruction1_out,
  output logic [ADDR_W-1:0]     pc0_out,
  output logic [ADDR_W-1:0]     pc1_out,
  output logic [ID_W-1:0]       id0_out,
  output logic [ID_W-1:0]       id1_out
);

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_DEPTH = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [INST_W-1:0] inst0_mem [DEPTH];
  logic [INST_W-1:0] inst1_mem [DEPTH];
  logic [ADDR_W-1:0] pc0_mem   [DEPTH];
  logic [ADDR_W-1:0] pc1_mem   [DEPTH];
  logic [ID_W-1:0]   id0_mem   [DEPTH];
  logic [ID_W-1:0]   id1_mem   [DEPTH];

  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic                  accept;
  logic                  pop;
  logic                  alloc;
  logic [ID_W-1:0]       new_id0;
  logic [ID_W-1:0]       new_id1;

  assign full   = (count == CNT_DEPTH);
  assign empty  = (count == '0);
  assign accept = push && !full;
  assign pop    = !empty && !stall;
  // A pair pushed alongside flush is discarded and must not consume ids.
  assign alloc  = accept && !flush;

  id_allocator u_id_allocator (
    .clk   (clk),
    .reset (reset),
    .alloc (alloc),
    .id0   (new_id0),
    .id1   (new_id1)
  );

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept)
        wptr <= wptr + PTR_ONE;
      if (pop)
        rptr <= rptr + PTR_ONE;
      if (accept && !pop)
        count <= count + CNT_ONE;
      else if (pop && !accept)
        count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && alloc) begin
      inst0_mem[wptr] <= instruction0_in;
      inst1_mem[wptr] <= instruction1_in;
      pc0_mem[wptr]   <= pc0_in;
      pc1_mem[wptr]   <= pc1_in;
      id0_mem[wptr]   <= new_id0;
      id1_mem[wptr]   <= new_id1;
    end
  end

  // Head slot is gated to zero when empty so stale storage never reaches issue.
  always_comb begin
    instruction0_out = '0;
    instruction1_out = '0;
    pc0_out          = '0;
    pc1_out          = '0;
    id0_out          = '0;
    id1_out          = '0;
    if (!empty) begin
      instruction0_out = inst0_mem[rptr];
      instruction1_out = inst1_mem[rptr];
      pc0_out          = pc0_mem[rptr];
      pc1_out          = pc1_mem[rptr];
      id0_out          = id0_mem[rptr];
      id1_out          = id1_mem[rptr];
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed plus random stimulus for fetch_queue, checked against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  localparam int DEPTH = FQ_DEPTH;
  localparam int DL2   = FQ_DEPTH_LOG2;

  logic              clk = 1'b0;
  logic              reset, flush, push, stall;
  logic [INST_W-1:0] instruction0_in, instruction1_in;
  logic [ADDR_W-1:0] pc0_in, pc1_in;
  logic              full, empty;
  logic [DL2:0]      count;
  logic [INST_W-1:0] instruction0_out, instruction1_out;
  logic [ADDR_W-1:0] pc0_out, pc1_out;
  logic [ID_W-1:0]   id0_out, id1_out;

  fetch_queue dut (
    .clk              (clk),
    .reset            (reset),
    .flush            (flush),
    .push             (push),
    .instruction0_in  (instruction0_in),
    .instruction1_in  (instruction1_in),
    .pc0_in           (pc0_in),
    .pc1_in           (pc1_in),
    .stall            (stall),
    .full             (full),
    .empty            (empty),
    .count            (count),
    .instruction0_out (instruction0_out),
    .instruction1_out (instruction1_out),
    .pc0_out          (pc0_out),
    .pc1_out          (pc1_out),
    .id0_out          (id0_out),
    .id1_out          (id1_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [INST_W-1:0] i0, i1;
    logic [ADDR_W-1:0] p0, p1;
    int                d0, d1;
  } ent_t;

  ent_t mq[$];
  int   next_id;
  int   tests_run = 0;
  int   tests_failed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    ent_t h;
    bit   e;
    e = (mq.size() == 0);
    chk("count", 64'(count), 64'(mq.size()));
    chk("empty", 64'(empty), 64'(e));
    chk("full",  64'(full),  64'(mq.size() == DEPTH));
    if (e) begin
      chk("inst0_out_empty", 64'(instruction0_out), 64'd0);
      chk("inst1_out_empty", 64'(instruction1_out), 64'd0);
      chk("pc0_out_empty",   64'(pc0_out), 64'd0);
      chk("pc1_out_empty",   64'(pc1_out), 64'd0);
      chk("id0_out_empty",   64'(id0_out), 64'd0);
      chk("id1_out_empty",   64'(id1_out), 64'd0);
    end else begin
      h = mq[0];
      chk("inst0_out", 64'(instruction0_out), 64'(h.i0));
      chk("inst1_out", 64'(instruction1_out), 64'(h.i1));
      chk("pc0_out",   64'(pc0_out), 64'(h.p0));
      chk("pc1_out",   64'(pc1_out), 64'(h.p1));
      chk("id0_out",   64'(id0_out), 64'(h.d0));
      chk("id1_out",   64'(id1_out), 64'(h.d1));
    end
  endtask

  // Reference behaviour at one clock edge, from the queue rules directly.
  task automatic model_edge();
    ent_t e;
    bit   was_full, do_pop, acc;
    if (reset) begin
      mq.delete();
      next_id = 2;
    end else if (flush) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      do_pop   = (mq.size() > 0) && !stall;
      acc      = push && !was_full;
      if (do_pop) void'(mq.pop_front());
      if (acc) begin
        e.i0 = instruction0_in; e.i1 = instruction1_in;
        e.p0 = pc0_in;          e.p1 = pc1_in;
        e.d0 = next_id;         e.d1 = next_id + 1;
        mq.push_back(e);
        next_id = (next_id + 2) % (1 << ID_W);
        if (next_id == 0) next_id = 2;
      end
    end
  endtask

  task automatic step_d(input bit r, input bit f, input bit p, input bit s,
                        input logic [INST_W-1:0] a0, input logic [ADDR_W-1:0] q0,
                        input logic [INST_W-1:0] a1, input logic [ADDR_W-1:0] q1);
    reset = r; flush = f; push = p; stall = s;
    instruction0_in = a0; pc0_in = q0; instruction1_in = a1; pc1_in = q1;
    #1;
    check_outs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic step(input bit r, input bit f, input bit p, input bit s);
    step_d(r, f, p, s, INST_W'($urandom), ADDR_W'($urandom),
           INST_W'($urandom), ADDR_W'($urandom));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; push = 1'b0; stall = 1'b0;
    instruction0_in = '0; instruction1_in = '0; pc0_in = '0; pc1_in = '0;
    @(posedge clk);
    model_edge();
    @(negedge clk);

    // Reset state, then one pair with one-cycle latency.
    step_d(0, 0, 1, 0, INST_W'(32'h11), ADDR_W'(32'h10), INST_W'(32'h22), ADDR_W'(32'h11));
    chk("t1_inst0", 64'(instruction0_out), 64'h11);
    chk("t1_inst1", 64'(instruction1_out), 64'h22);
    chk("t1_id0",   64'(id0_out), 64'd2);
    chk("t1_id1",   64'(id1_out), 64'd3);
    step(0, 0, 0, 0);
    chk("t1_drained", 64'(empty), 64'd1);
    step(0, 0, 0, 0);

    // Fill while stalled, drop the fifth push, drain in order.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    chk("t2_full",  64'(full),  64'd1);
    chk("t2_count", 64'(count), 64'd4);
    step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_drain_id0", 64'(id0_out), 64'(2 + 2 * i));
      step(0, 0, 0, 0);
    end
    step(0, 0, 0, 0);

    // Full with a pop in the same cycle: that push is still dropped.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);

    // Flush with a concurrent push consumes no id.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    step(0, 1, 1, 1);
    chk("t4_empty", 64'(empty), 64'd1);
    chk("t4_id0_zero", 64'(id0_out), 64'd0);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);

    // Id wrap skips 0 and 1.
    step(1, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Reset dominates flush and push.
    step(0, 0, 1, 1);
    step(0, 0, 1, 1);
    step(1, 1, 1, 1);
    chk("t6_count", 64'(count), 64'd0);
    step(0, 0, 1, 0);
    chk("t6_id0", 64'(id0_out), 64'd2);
    chk("t6_id1", 64'(id1_out), 64'd3);
    step(0, 0, 0, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
